// File: rtl/mem_master_pkg.sv
// Shared definitions for the memory master: default widths, FSM encoding
// and memory direction codes.
package mem_master_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 4;
    localparam int LEN_W_DEF  = 4;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BEAT  = 2'd1,
        RD_ISSUE = 2'd2,
        RD_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/mem_master_if.sv
// CPU-side request/data handshakes and memory-side port of the memory master.
// Handshake rule for req, wdata and rdata: a beat transfers on the rising
// edge where valid and ready are both high; valid does not wait on ready.
interface mem_master_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int LEN_W  = 4
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;
    logic              wdata_valid;
    logic              wdata_ready;
    logic [DATA_W-1:0] wdata;
    logic              rdata_valid;
    logic              rdata_ready;
    logic [DATA_W-1:0] rdata;
    logic              done;
    logic              mem_rw;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  req_valid, req_write, req_addr, req_len,
        input  wdata_valid, wdata, rdata_ready, mem_rdata,
        output req_ready, wdata_ready, rdata_valid, rdata, done,
        output mem_rw, mem_addr, mem_wdata
    );

    modport slave (
        output req_valid, req_write, req_addr, req_len,
        output wdata_valid, wdata, rdata_ready, mem_rdata,
        input  req_ready, wdata_ready, rdata_valid, rdata, done,
        input  mem_rw, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_burst_ctr.sv
// Burst address/length tracker: loaded at request accept, stepped on each
// non-final beat, flags the last beat when the remaining count reaches zero.
module mem_burst_ctr #(
    parameter int ADDR_W = 4,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [LEN_W-1:0]  load_len,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  beats_q;

    // Address wraps naturally modulo 2^ADDR_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            beats_q <= '0;
        end else if (load) begin
            addr_q  <= load_addr;
            beats_q <= load_len;
        end else if (step) begin
            addr_q  <= addr_q + 1'b1;
            beats_q <= beats_q - 1'b1;
        end
    end

    assign addr = addr_q;
    assign last = (beats_q == '0);
endmodule

// File: rtl/mem_master.sv
// Memory master: accepts load/store bursts from the MEM stage and owns the
// single-port synchronous memory. Stores write in the beat-accept cycle;
// loads alternate an issue cycle and a response cycle per word.
module mem_master
    import mem_master_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    mem_master_if.master   bus,
    output state_t         state_dbg
);
    state_t            state, next_state;
    logic              load, step, done_set, done_q;
    logic              last;
    logic [ADDR_W-1:0] addr;
    logic              req_ready_c, wdata_ready_c, rdata_valid_c, mem_rw_c;

    mem_burst_ctr #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_ctr (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .step      (step),
        .load_addr (bus.req_addr),
        .load_len  (bus.req_len),
        .addr      (addr),
        .last      (last)
    );

    // State register and the one-cycle done pulse after a burst's last beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            done_q <= 1'b0;
        end else begin
            state  <= next_state;
            done_q <= done_set;
        end
    end

    // Next state, handshake readies and memory direction.
    always_comb begin
        next_state    = state;
        load          = 1'b0;
        step          = 1'b0;
        done_set      = 1'b0;
        req_ready_c   = 1'b0;
        wdata_ready_c = 1'b0;
        rdata_valid_c = 1'b0;
        mem_rw_c      = MEM_READ;
        case (state)
            IDLE: begin
                req_ready_c = 1'b1;
                if (bus.req_valid) begin
                    load       = 1'b1;
                    next_state = bus.req_write ? WR_BEAT : RD_ISSUE;
                end
            end
            WR_BEAT: begin
                wdata_ready_c = 1'b1;
                if (bus.wdata_valid) begin
                    mem_rw_c = MEM_WRITE;
                    if (last) begin
                        next_state = IDLE;
                        done_set   = 1'b1;
                    end else begin
                        step = 1'b1;
                    end
                end
            end
            RD_ISSUE: begin
                next_state = RD_RESP;
            end
            RD_RESP: begin
                rdata_valid_c = 1'b1;
                if (bus.rdata_ready) begin
                    if (last) begin
                        next_state = IDLE;
                        done_set   = 1'b1;
                    end else begin
                        step       = 1'b1;
                        next_state = RD_ISSUE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
        // No memory write may land on a reset edge.
        if (rst) mem_rw_c = MEM_READ;
    end

    // Address stays on addr_q through RD_RESP so the memory output is stable
    // while the consumer stalls.
    assign bus.req_ready   = req_ready_c;
    assign bus.wdata_ready = wdata_ready_c;
    assign bus.rdata_valid = rdata_valid_c;
    assign bus.rdata       = bus.mem_rdata;
    assign bus.done        = done_q;
    assign bus.mem_rw      = mem_rw_c;
    assign bus.mem_addr    = addr;
    assign bus.mem_wdata   = bus.wdata;
    assign state_dbg       = state;
endmodule

// File: tb/tb_mem_master.sv
// Directed bench for mem_master with a behavioural 16x32 synchronous memory.
module tb_mem_master;
    import mem_master_pkg::*;

    logic        clk;
    logic        rst;
    state_t      state_dbg;
    int          n_assert;
    int          n_fail;
    logic [31:0] mem_arr [16];
    logic [31:0] wd [8];
    logic [31:0] exp_q [$];
    logic [31:0] snap [16];
    logic [3:0]  ea;
    int          cnt;

    mem_master_if bus ();

    mem_master dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // memory model: write on mem_rw, read data registered (1-cycle latency)
    always @(posedge clk) begin
        if (bus.mem_rw) mem_arr[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= mem_arr[bus.mem_addr];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue_req(input logic w, input logic [3:0] a, input logic [3:0] l);
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_len   = l;
        @(negedge clk);
        check("req_ready_idle", {31'b0, bus.req_ready}, 32'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic do_store(input logic [3:0] addr, input int len, input bit gaps);
        logic [3:0] a;
        issue_req(1'b1, addr, len[3:0]);
        for (int b = 0; b <= len; b++) begin
            if (gaps && b > 0) begin
                bus.wdata_valid = 1'b0;
                @(negedge clk);
                check("gap_no_write", {31'b0, bus.mem_rw}, 32'd0);
                check("gap_wready", {31'b0, bus.wdata_ready}, 32'd1);
                @(posedge clk); #1;
            end
            bus.wdata_valid = 1'b1;
            bus.wdata       = wd[b];
            @(negedge clk);
            a = addr + b[3:0];
            check("wr_rw", {31'b0, bus.mem_rw}, 32'd1);
            check("wr_addr", {28'b0, bus.mem_addr}, {28'b0, a});
            check("wr_done_low", {31'b0, bus.done}, 32'd0);
            @(posedge clk); #1;
        end
        bus.wdata_valid = 1'b0;
        @(negedge clk);
        check("wr_done_pulse", {31'b0, bus.done}, 32'd1);
        check("wr_back_idle", {31'b0, bus.req_ready}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("wr_done_once", {31'b0, bus.done}, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic do_load(input logic [3:0] addr, input int len, input int stall);
        logic [31:0] held;
        logic [3:0]  a;
        int          c;
        issue_req(1'b0, addr, len[3:0]);
        for (int b = 0; b <= len; b++) begin
            c = 0;
            do begin
                @(negedge clk);
                c++;
            end while (!bus.rdata_valid && c < 10);
            check("rd_latency", c, 32'd2);
            a = addr + b[3:0];
            check("rd_addr", {28'b0, bus.mem_addr}, {28'b0, a});
            held = bus.rdata;
            for (int s = 0; s < stall; s++) begin
                @(posedge clk);
                @(negedge clk);
                check("stall_valid", {31'b0, bus.rdata_valid}, 32'd1);
                check("stall_rdata", bus.rdata, held);
                check("stall_rw", {31'b0, bus.mem_rw}, 32'd0);
            end
            check("rd_data", held, exp_q.pop_front());
            check("rd_done_low", {31'b0, bus.done}, 32'd0);
            bus.rdata_ready = 1'b1;
            @(posedge clk); #1;
            bus.rdata_ready = 1'b0;
        end
        @(negedge clk);
        check("rd_done_pulse", {31'b0, bus.done}, 32'd1);
        check("rd_no_extra", {31'b0, bus.rdata_valid}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("rd_done_once", {31'b0, bus.done}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus.req_valid   = 1'b0;
        bus.req_write   = 1'b0;
        bus.req_addr    = '0;
        bus.req_len     = '0;
        bus.wdata_valid = 1'b0;
        bus.wdata       = '0;
        bus.rdata_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_state", {30'b0, state_dbg}, {30'b0, IDLE});
        check("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
        check("rst_wready", {31'b0, bus.wdata_ready}, 32'd0);
        check("rst_rvalid", {31'b0, bus.rdata_valid}, 32'd0);
        check("rst_done", {31'b0, bus.done}, 32'd0);
        check("rst_mem_rw", {31'b0, bus.mem_rw}, 32'd0);
        check("rst_mem_addr", {28'b0, bus.mem_addr}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: single store then single load
        wd[0] = 32'hDEADBEEF;
        do_store(4'h3, 0, 1'b0);
        check("t1_mem3", mem_arr[3], 32'hDEADBEEF);
        exp_q.push_back(32'hDEADBEEF);
        do_load(4'h3, 0, 0);

        // 2: wrapping store burst and matching load burst
        for (int i = 0; i < 4; i++) wd[i] = 32'hA0 + i;
        do_store(4'hE, 3, 1'b0);
        check("t2_memE", mem_arr[14], 32'h000000A0);
        check("t2_memF", mem_arr[15], 32'h000000A1);
        check("t2_mem0", mem_arr[0], 32'h000000A2);
        check("t2_mem1", mem_arr[1], 32'h000000A3);
        for (int i = 0; i < 4; i++) exp_q.push_back(32'hA0 + i);
        do_load(4'hE, 3, 0);

        // 3: load burst with 5 stall cycles per beat
        for (int i = 0; i < 3; i++) exp_q.push_back(32'hA0 + i);
        do_load(4'hE, 2, 5);

        // 4: store burst len 7 with gaps between beats
        for (int i = 0; i < 8; i++) wd[i] = 32'h4000_0000 + i;
        do_store(4'h4, 7, 1'b1);
        for (int i = 0; i < 8; i++) check("t4_mem", mem_arr[4 + i], 32'h4000_0000 + i);

        // 5: reset during third beat of a store burst len 5 at addr 9
        for (int i = 0; i < 16; i++) snap[i] = mem_arr[i];
        for (int i = 0; i < 6; i++) wd[i] = 32'h5500_0000 + i;
        issue_req(1'b1, 4'h9, 4'd5);
        for (int b = 0; b < 2; b++) begin
            bus.wdata_valid = 1'b1;
            bus.wdata       = wd[b];
            @(posedge clk); #1;
        end
        bus.wdata = wd[2];
        rst = 1'b1;
        @(negedge clk);
        check("t5_rw_at_rst", {31'b0, bus.mem_rw}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.wdata_valid = 1'b0;
        @(negedge clk);
        check("t5_state", {30'b0, state_dbg}, {30'b0, IDLE});
        check("t5_req_ready", {31'b0, bus.req_ready}, 32'd1);
        check("t5_wready", {31'b0, bus.wdata_ready}, 32'd0);
        check("t5_mem_addr", {28'b0, bus.mem_addr}, 32'd0);
        check("t5_no_done", {31'b0, bus.done}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("t5_no_done2", {31'b0, bus.done}, 32'd0);
        check("t5_mem9", mem_arr[9], 32'h5500_0000);
        check("t5_memA", mem_arr[10], 32'h5500_0001);
        for (int i = 11; i < 15; i++) check("t5_unchanged", mem_arr[i], snap[i]);
        @(posedge clk); #1;

        // 6: request held during a burst is taken only on the first IDLE cycle
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 4'h0;
        bus.req_len   = 4'd1;
        @(posedge clk); #1;
        bus.req_write   = 1'b0;
        bus.req_addr    = 4'h5;
        bus.req_len     = 4'd0;
        bus.wdata_valid = 1'b1;
        bus.wdata       = 32'h600D_0000;
        @(negedge clk);
        check("t6_busy0", {31'b0, bus.req_ready}, 32'd0);
        @(posedge clk); #1;
        bus.wdata = 32'h600D_0001;
        @(negedge clk);
        check("t6_busy1", {31'b0, bus.req_ready}, 32'd0);
        check("t6_addr1", {28'b0, bus.mem_addr}, 32'd1);
        @(posedge clk); #1;
        bus.wdata_valid = 1'b0;
        @(negedge clk);
        check("t6_idle_ready", {31'b0, bus.req_ready}, 32'd1);
        check("t6_done", {31'b0, bus.done}, 32'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("t6_accepted", {30'b0, state_dbg}, {30'b0, RD_ISSUE});
        check("t6_ready_low", {31'b0, bus.req_ready}, 32'd0);
        check("t6_mem0", mem_arr[0], 32'h600D_0000);
        check("t6_mem1", mem_arr[1], 32'h600D_0001);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!bus.rdata_valid && cnt < 10);
        check("t6_rvalid", {31'b0, bus.rdata_valid}, 32'd1);
        ea = bus.mem_addr;
        check("t6_rd_addr", {28'b0, ea}, 32'd5);
        check("t6_rdata", bus.rdata, 32'h4000_0001);
        bus.rdata_ready = 1'b1;
        @(posedge clk); #1;
        bus.rdata_ready = 1'b0;
        @(negedge clk);
        check("t6_rd_done", {31'b0, bus.done}, 32'd1);
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
